pipeline_ctrl: RTL and testbench



---
 rtl/cpu_types_pkg.sv | 33 +++
 rtl/sat_counter.sv | 27 ++
 rtl/pipeline_ctrl.sv | 120 ++++++++++++
 tb/tb_pipeline_ctrl.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_types_pkg.sv
// Shared CPU types: register selects, pipeline-controller state and the
// per-cycle latch/PC control bundle with its named settings.
package cpu_types_pkg;

    localparam int REGBITS = 5;

    typedef logic [REGBITS-1:0] regbits_t;

    typedef enum logic {
        RUN    = 1'b0,
        HALTED = 1'b1
    } pctrl_state_t;

    typedef struct packed {
        logic pc_en;
        logic f_en;
        logic d_en;
        logic e_en;
        logic m_en;
        logic f_flush;
        logic d_flush;
        logic e_flush;
    } pctrl_ctl_t;

    // Bit order below: {pc_en, f_en, d_en, e_en, m_en, f_flush, d_flush, e_flush}
    localparam pctrl_ctl_t CTL_FREEZE  = 8'b0_0000_000;
    localparam pctrl_ctl_t CTL_HALT    = 8'b0_1111_111;
    localparam pctrl_ctl_t CTL_BRANCH  = 8'b1_1111_111;
    localparam pctrl_ctl_t CTL_LOADUSE = 8'b0_0011_001;
    localparam pctrl_ctl_t CTL_IMISS   = 8'b0_1111_100;
    localparam pctrl_ctl_t CTL_ADVANCE = 8'b1_1111_000;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter: increments on inc, sticks at all-ones, never wraps.
module sat_counter #(
    parameter int CNT_W = 32
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             inc,
    output logic [CNT_W-1:0] count
);

    localparam logic [CNT_W-1:0] ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    logic [CNT_W-1:0] r_count;

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of block evaluation order.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_count <= '0;
        end else if (inc && (r_count != '1)) begin
            r_count <= r_count + ONE;
        end
    end

    assign count = r_count;

endmodule

// File: rtl/pipeline_ctrl.sv
// Stall/flush controller for the five-stage pipeline: prioritises memory
// stalls, halt, mem-stage redirects, load-use and icache misses.
module pipeline_ctrl
    import cpu_types_pkg::*;
#(
    parameter int CNT_W = 32,
    parameter int REG_W = 5
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             ihit,
    input  logic             dhit,
    input  logic             mem_dREN,
    input  logic             mem_dWEN,
    input  logic             mem_branch,
    input  logic             mem_halt,
    input  regbits_t         dec_rs,
    input  regbits_t         dec_rt,
    input  logic             ex_memread,
    input  regbits_t         ex_wsel,
    output logic             pc_en,
    output logic             flatch_en,
    output logic             dlatch_en,
    output logic             elatch_en,
    output logic             mlatch_en,
    output logic             flatch_flush,
    output logic             dlatch_flush,
    output logic             elatch_flush,
    output logic             halt,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    pctrl_state_t r_state;
    pctrl_state_t w_state_next;
    pctrl_ctl_t   w_ctl;
    logic         w_mem_stall;
    logic         w_lu_haz;
    logic         w_stall_inc;
    logic         w_flush_inc;

    assign w_mem_stall = (mem_dREN | mem_dWEN) & ~dhit;

    // Writes to $zero never create a dependence, so wsel==0 cannot hazard.
    assign w_lu_haz = ex_memread
                    & (ex_wsel[REG_W-1:0] != '0)
                    & ((ex_wsel[REG_W-1:0] == dec_rs[REG_W-1:0])
                     | (ex_wsel[REG_W-1:0] == dec_rt[REG_W-1:0]));

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_state <= RUN;
        end else begin
            r_state <= w_state_next;
        end
    end

    // NOTE: every always_comb output gets a default first so no path
    // leaves a signal unassigned and infers a latch.
    always_comb begin
        w_ctl        = CTL_FREEZE;
        w_state_next = r_state;
        w_stall_inc  = 1'b0;
        w_flush_inc  = 1'b0;
        if (!RST) begin
            case (r_state)
                RUN: begin
                    if (w_mem_stall) begin
                        w_stall_inc = 1'b1;
                    end else if (mem_halt) begin
                        w_ctl        = CTL_HALT;
                        w_state_next = HALTED;
                    end else if (mem_branch) begin
                        w_ctl       = CTL_BRANCH;
                        w_flush_inc = 1'b1;
                    end else if (w_lu_haz) begin
                        w_ctl       = CTL_LOADUSE;
                        w_stall_inc = 1'b1;
                    end else if (!ihit) begin
                        w_ctl       = CTL_IMISS;
                        w_stall_inc = 1'b1;
                    end else begin
                        w_ctl = CTL_ADVANCE;
                    end
                end
                HALTED: begin
                    w_ctl = CTL_FREEZE;
                end
                default: begin
                    w_ctl = CTL_FREEZE;
                end
            endcase
        end
    end

    assign pc_en        = w_ctl.pc_en;
    assign flatch_en    = w_ctl.f_en;
    assign dlatch_en    = w_ctl.d_en;
    assign elatch_en    = w_ctl.e_en;
    assign mlatch_en    = w_ctl.m_en;
    assign flatch_flush = w_ctl.f_flush;
    assign dlatch_flush = w_ctl.d_flush;
    assign elatch_flush = w_ctl.e_flush;
    assign halt         = (r_state == HALTED);

    sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
        .CLK   (CLK),
        .RST   (RST),
        .inc   (w_stall_inc),
        .count (stall_cnt)
    );

    sat_counter #(.CNT_W(CNT_W)) u_flush_cnt (
        .CLK   (CLK),
        .RST   (RST),
        .inc   (w_flush_inc),
        .count (flush_cnt)
    );

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Self-checking bench: a default-width and a 4-bit-counter instance share
// stimulus; a spec-level model is compared every negedge, plus literal checks.
module tb_pipeline_ctrl;
    import cpu_types_pkg::*;

    logic     CLK = 1'b0;
    logic     RST = 1'b1;
    logic     ihit = 1'b1, dhit = 1'b1;
    logic     mem_dREN = 1'b0, mem_dWEN = 1'b0, mem_branch = 1'b0, mem_halt = 1'b0;
    logic     ex_memread = 1'b0;
    regbits_t dec_rs = 5'd1, dec_rt = 5'd2, ex_wsel = 5'd3;

    logic        pc_en_a, fen_a, den_a, een_a, men_a, ffl_a, dfl_a, efl_a, halt_a;
    logic [31:0] stall_a, flush_a;
    logic        pc_en_b, fen_b, den_b, een_b, men_b, ffl_b, dfl_b, efl_b, halt_b;
    logic [3:0]  stall_b, flush_b;
    logic [7:0]  ctl_a, ctl_b;

    assign ctl_a = {pc_en_a, fen_a, den_a, een_a, men_a, ffl_a, dfl_a, efl_a};
    assign ctl_b = {pc_en_b, fen_b, den_b, een_b, men_b, ffl_b, dfl_b, efl_b};

    pipeline_ctrl u_dut_a (
        .CLK(CLK), .RST(RST), .ihit(ihit), .dhit(dhit),
        .mem_dREN(mem_dREN), .mem_dWEN(mem_dWEN), .mem_branch(mem_branch),
        .mem_halt(mem_halt), .dec_rs(dec_rs), .dec_rt(dec_rt),
        .ex_memread(ex_memread), .ex_wsel(ex_wsel),
        .pc_en(pc_en_a), .flatch_en(fen_a), .dlatch_en(den_a), .elatch_en(een_a),
        .mlatch_en(men_a), .flatch_flush(ffl_a), .dlatch_flush(dfl_a),
        .elatch_flush(efl_a), .halt(halt_a), .stall_cnt(stall_a), .flush_cnt(flush_a)
    );

    pipeline_ctrl #(.CNT_W(4)) u_dut_b (
        .CLK(CLK), .RST(RST), .ihit(ihit), .dhit(dhit),
        .mem_dREN(mem_dREN), .mem_dWEN(mem_dWEN), .mem_branch(mem_branch),
        .mem_halt(mem_halt), .dec_rs(dec_rs), .dec_rt(dec_rt),
        .ex_memread(ex_memread), .ex_wsel(ex_wsel),
        .pc_en(pc_en_b), .flatch_en(fen_b), .dlatch_en(den_b), .elatch_en(een_b),
        .mlatch_en(men_b), .flatch_flush(ffl_b), .dlatch_flush(dfl_b),
        .elatch_flush(efl_b), .halt(halt_b), .stall_cnt(stall_b), .flush_cnt(flush_b)
    );

    always #5 CLK = ~CLK;

    int errors = 0;
    int checks = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    // ---------------- behavioural model ----------------
    typedef enum {A_RESET, A_FROZEN, A_MSTALL, A_HALT, A_BRANCH, A_LU, A_IMISS, A_RUN} act_t;

    bit     m_halted = 1'b0;
    longint m_stall = 0, m_flush = 0;
    int     m_stall4 = 0, m_flush4 = 0;
    act_t   m_act;
    act_t   c_act;

    function automatic act_t classify();
        bit dep;
        dep = ex_memread && (ex_wsel != 0) && (ex_wsel == dec_rs || ex_wsel == dec_rt);
        if (RST)                                 return A_RESET;
        if (m_halted)                            return A_FROZEN;
        if ((mem_dREN || mem_dWEN) && !dhit)     return A_MSTALL;
        if (mem_halt)                            return A_HALT;
        if (mem_branch)                          return A_BRANCH;
        if (dep)                                 return A_LU;
        if (!ihit)                               return A_IMISS;
        return A_RUN;
    endfunction

    // {pc_en, f_en, d_en, e_en, m_en, f_flush, d_flush, e_flush}
    function automatic logic [7:0] ctl_of(input act_t a);
        case (a)
            A_HALT:   return 8'b0111_1111;
            A_BRANCH: return 8'b1111_1111;
            A_LU:     return 8'b0001_1001;
            A_IMISS:  return 8'b0111_1100;
            A_RUN:    return 8'b1111_1000;
            default:  return 8'b0000_0000;
        endcase
    endfunction

    always @(posedge CLK or posedge RST) begin
        if (RST) begin
            m_halted = 1'b0;
            m_stall  = 0;
            m_flush  = 0;
            m_stall4 = 0;
            m_flush4 = 0;
        end else begin
            m_act = classify();
            if (m_act == A_MSTALL || m_act == A_LU || m_act == A_IMISS) begin
                if (m_stall < 64'hFFFF_FFFF) m_stall++;
                if (m_stall4 < 15)           m_stall4++;
            end
            if (m_act == A_BRANCH) begin
                if (m_flush < 64'hFFFF_FFFF) m_flush++;
                if (m_flush4 < 15)           m_flush4++;
            end
            if (m_act == A_HALT) m_halted = 1'b1;
        end
    end

    always @(negedge CLK) begin
        c_act = classify();
        check("model_ctl_a",   ctl_a,   ctl_of(c_act));
        check("model_ctl_b",   ctl_b,   ctl_of(c_act));
        check("model_halt_a",  halt_a,  m_halted);
        check("model_halt_b",  halt_b,  m_halted);
        check("model_stall_a", stall_a, m_stall);
        check("model_flush_a", flush_a, m_flush);
        check("model_stall_b", stall_b, m_stall4);
        check("model_flush_b", flush_b, m_flush4);
    end

    // ---------------- directed stimulus ----------------
    initial begin
        repeat (2) step();
        check("rst_ctl", ctl_a, 8'h00);
        check("rst_halt", halt_a, 0);
        RST = 1'b0;

        repeat (4) step();
        check("run_ctl", ctl_a, 8'hF8);
        check("run_stall", stall_a, 0);
        check("run_flush", flush_a, 0);

        // load-use on rs
        ex_memread = 1'b1; ex_wsel = 5'd8; dec_rs = 5'd8;
        #1 check("lu_ctl", ctl_a, 8'h19);
        step();
        ex_memread = 1'b0;
        #1 check("lu_bubble_ctl", ctl_a, 8'hF8);
        check("lu_stall", stall_a, 1);

        // load to $zero never hazards
        ex_memread = 1'b1; ex_wsel = 5'd0; dec_rs = 5'd0;
        #1 check("lu_r0_ctl", ctl_a, 8'hF8);
        step();
        check("lu_r0_stall", stall_a, 1);

        // load-use on rt
        ex_wsel = 5'd5; dec_rs = 5'd1; dec_rt = 5'd5;
        step();
        ex_memread = 1'b0; ex_wsel = 5'd3; dec_rt = 5'd2;
        check("lu_rt_stall", stall_a, 2);

        // dcache miss for three cycles
        mem_dREN = 1'b1; dhit = 1'b0;
        #1 check("dmiss_ctl", ctl_a, 8'h00);
        repeat (3) step();
        dhit = 1'b1;
        #1 check("dmiss_hit_ctl", ctl_a, 8'hF8);
        step();
        mem_dREN = 1'b0;
        check("dmiss_stall", stall_a, 5);

        // branch beats load-use and icache miss
        mem_branch = 1'b1; ex_memread = 1'b1; ex_wsel = 5'd8; dec_rs = 5'd8; ihit = 1'b0;
        #1 check("br_ctl", ctl_a, 8'hFF);
        step();
        mem_branch = 1'b0; ex_memread = 1'b0; ex_wsel = 5'd3; dec_rs = 5'd1;
        check("br_flush", flush_a, 1);
        check("br_stall", stall_a, 5);

        // icache miss alone
        #1 check("imiss_ctl", ctl_a, 8'h7C);
        step();
        ihit = 1'b1;
        check("imiss_stall", stall_a, 6);

        // asynchronous reset mid-cycle
        #2 RST = 1'b1;
        #1 check("arst_ctl", ctl_a, 8'h00);
        check("arst_stall", stall_a, 0);
        check("arst_flush", flush_a, 0);
        step();
        RST = 1'b0;
        step();

        // halt held behind a store miss, also racing a branch
        mem_halt = 1'b1; mem_dWEN = 1'b1; dhit = 1'b0; mem_branch = 1'b1;
        #1 check("halt_stall_ctl", ctl_a, 8'h00);
        repeat (2) step();
        dhit = 1'b1;
        #1 check("halt_accept_ctl", ctl_a, 8'h7F);
        check("halt_pre", halt_a, 0);
        step();
        check("halt_set", halt_a, 1);
        check("halt_ctl", ctl_a, 8'h00);

        for (int i = 0; i < 10; i++) begin
            ihit = i[0]; dhit = i[1]; mem_dREN = i[2]; mem_dWEN = 1'b0;
            mem_branch = ~i[0]; mem_halt = i[1];
            ex_memread = 1'b1; ex_wsel = 5'(i + 1); dec_rs = 5'(i + 1);
            #1 check("halted_ctl", ctl_a, 8'h00);
            step();
        end
        check("halted_stall", stall_a, 2);
        check("halted_flush", flush_a, 0);
        check("halted_sticky", halt_a, 1);

        // saturation on the 4-bit instance
        ihit = 1'b1; mem_branch = 1'b0; mem_halt = 1'b0; ex_memread = 1'b0;
        ex_wsel = 5'd3; dec_rs = 5'd1; dec_rt = 5'd2;
        RST = 1'b1;
        step();
        RST = 1'b0;
        mem_dREN = 1'b1; dhit = 1'b0;
        repeat (14) step();
        check("sat_pre_b", stall_b, 14);
        repeat (3) step();
        check("sat_b", stall_b, 15);
        check("sat_wide_a", stall_a, 17);
        mem_dREN = 1'b0; dhit = 1'b1;
        step();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
